div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider in the EX stage. It is the producer side of the HI/LO register write port.
- Accepts DIV/DIVU operands and stalls the pipeline while it iterates. On completion it presents remainder for HI, quotient for LO, and a HI/LO write strobe.
- Supports annulment of an in-flight divide, used on flush/exception.

---
 rtl/div_unit_pkg.sv | 22 ++
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit_step.sv | 14 +
 rtl/div_unit.sv | 142 ++++++++++++++
 tb/tb_div_unit.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the radix-2 restoring divider (HI/LO producer).
package div_unit_pkg;
  localparam int RegBusW       = 32;
  localparam int DoubleRegBusW = 2 * RegBusW;

  typedef logic [RegBusW-1:0]       RegBus;
  typedef logic [DoubleRegBusW-1:0] DoubleRegBus;

  localparam logic  RstEnable         = 1'b0;
  localparam RegBus ZeroWord          = '0;
  localparam logic  DivResultReady    = 1'b1;
  localparam logic  DivResultNotReady = 1'b0;
  localparam logic  DivStart          = 1'b1;
  localparam logic  DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
endpackage

// File: rtl/div_unit_if.sv
// EX-stage <-> divider handshake and HI/LO result bus.
interface div_unit_if #(parameter int DW = 32) ();
  logic          start_i;
  logic          annul_i;
  logic          signed_div_i;
  logic [DW-1:0] opdata1_i;
  logic [DW-1:0] opdata2_i;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;
  logic          whilo_o;
  logic          ready_o;
  logic          stallreq_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  hi_o, lo_o, whilo_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output hi_o, lo_o, whilo_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring iteration: compare shifted partial remainder with divisor magnitude.
module div_step #(parameter int DW = 32) (
  input  logic [DW:0]   i_rem,
  input  logic [DW-1:0] i_dvs,
  output logic [DW-1:0] o_rem,
  output logic          o_qbit
);
  logic [DW-1:0] w_diff;

  // When the subtraction succeeds the true difference is < divisor, so DW bits suffice.
  assign o_qbit = (i_rem >= {1'b0, i_dvs});
  assign w_diff = i_rem[DW-1:0] - i_dvs;
  assign o_rem  = o_qbit ? w_diff : i_rem[DW-1:0];
endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring DIV/DIVU unit; remainder to HI, quotient to LO.
// Optional DIV_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DW    = RegBusW,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  div_state_e    r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0] r_rem, r_quo, r_dvs, r_hi, r_lo;
  logic          r_neg1, r_neg2, r_first;

  logic          w_go, w_neg1, w_neg2, w_div0, w_early, w_last;
  logic [DW-1:0] w_mag1, w_mag2, w_step_rem, w_quo_nx, w_fin_lo, w_fin_hi;
  logic          w_qbit, w_ready, w_whilo;

  assign w_go   = (bus.start_i == DivStart) & ~bus.annul_i;
  assign w_neg1 = bus.signed_div_i & bus.opdata1_i[DW-1];
  assign w_neg2 = bus.signed_div_i & bus.opdata2_i[DW-1];
  assign w_mag1 = w_neg1 ? -bus.opdata1_i : bus.opdata1_i;
  assign w_mag2 = w_neg2 ? -bus.opdata2_i : bus.opdata2_i;
  assign w_div0 = (bus.opdata2_i == ZeroWord);
  assign w_last = (r_cnt == CNT_W'(DW-1));

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (w_mag1 < w_mag2);
`else
  assign w_early = 1'b0;
`endif

  div_step #(.DW(DW)) u_step (
    .i_rem  ({r_rem, r_quo[DW-1]}),
    .i_dvs  (r_dvs),
    .o_rem  (w_step_rem),
    .o_qbit (w_qbit)
  );

  // Final iteration's result feeds sign correction directly so END holds corrected values.
  assign w_quo_nx = {r_quo[DW-2:0], w_qbit};
  assign w_fin_lo = (r_neg1 ^ r_neg2) ? -w_quo_nx : w_quo_nx;
  assign w_fin_hi = r_neg1 ? -w_step_rem : w_step_rem;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) r_state <= DivFree;
    else                  r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DivFree: begin
        if (w_go) begin
          if (w_div0)       w_next = DivByZero;
          else if (w_early) w_next = DivEnd;
          else              w_next = DivOn;
        end
      end
      DivByZero: w_next = bus.annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (bus.annul_i) w_next = DivFree;
        else if (w_last) w_next = DivEnd;
      end
      DivEnd: begin
        if (bus.annul_i || bus.start_i == DivStop) w_next = DivFree;
      end
      default: w_next = DivFree;
    endcase
  end

  always_comb begin
    w_ready = DivResultNotReady;
    w_whilo = 1'b0;
    if (r_state == DivEnd) begin
      w_ready = DivResultReady;
      w_whilo = r_first & ~bus.annul_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg1  <= 1'b0;
      r_neg2  <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_first <= 1'b0;
      case (r_state)
        DivFree: begin
          if (w_go) begin
            r_neg1 <= w_neg1;
            r_neg2 <= w_neg2;
            r_dvs  <= w_mag2;
            r_quo  <= w_mag1;
            r_rem  <= '0;
            r_cnt  <= '0;
            if (!w_div0 && w_early) begin
              r_hi    <= bus.opdata1_i;
              r_lo    <= ZeroWord;
              r_first <= 1'b1;
            end
          end
        end
        DivByZero: begin
          if (!bus.annul_i) begin
            r_hi    <= ZeroWord;
            r_lo    <= ZeroWord;
            r_first <= 1'b1;
          end
        end
        DivOn: begin
          if (!bus.annul_i) begin
            r_rem <= w_step_rem;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_hi    <= w_fin_hi;
              r_lo    <= w_fin_lo;
              r_first <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi_o       = r_hi;
  assign bus.lo_o       = r_lo;
  assign bus.ready_o    = w_ready;
  assign bus.whilo_o    = w_whilo;
  assign bus.stallreq_o = bus.start_i & ~w_ready & ~bus.annul_i;
endmodule

// File: tb/tb_div_unit.sv
// Directed table-driven bench for div_unit plus annul/reset sequences.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_unit_if #(.DW(32)) bus ();
  div_unit #(.DW(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 33;
`endif

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int wcnt;
    string tag;
    tag = $sformatf("v%0d", idx);
    bus.signed_div_i = v.sgn;
    bus.opdata1_i    = v.a;
    bus.opdata2_i    = v.b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    #1;
    chk({tag, " stall_at_start"}, 32'(bus.stallreq_o), 32'd1);
    lat  = 0;
    wcnt = 0;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      tick();
      if (n == 1) begin
        bus.opdata1_i    = 32'h5A5A5A5A;
        bus.opdata2_i    = 32'h00000000;
        bus.signed_div_i = ~v.sgn;
      end
      if (bus.whilo_o) wcnt++;
      if (bus.ready_o) lat = n;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " hi"}, bus.hi_o, v.hi);
    chk({tag, " lo"}, bus.lo_o, v.lo);
    chk({tag, " stall_when_ready"}, 32'(bus.stallreq_o), 32'd0);
    tick();
    if (bus.whilo_o) wcnt++;
    chk({tag, " whilo_pulses"}, 32'(wcnt), 32'd1);
    chk({tag, " ready_held"}, 32'(bus.ready_o), 32'd1);
    chk({tag, " lo_held"}, bus.lo_o, v.lo);
    bus.start_i = 1'b0;
    tick();
    chk({tag, " ready_drop"}, 32'(bus.ready_o), 32'd0);
  endtask

  initial begin
    int rcnt;
    int wcnt;
    int lat;
    tbl[0]  = '{1'b0, 32'd100,        32'd7,        32'd2,        32'd14,         33};
    tbl[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD,   33};
    tbl[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD,   33};
    tbl[3]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,          33};
    tbl[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000,   33};
    tbl[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'd0,        32'hFFFFFFFF,   33};
    tbl[6]  = '{1'b0, 32'd5,          32'd0,        32'd0,        32'd0,          2};
    tbl[7]  = '{1'b0, 32'd3,          32'd10,       32'd3,        32'd0,          EARLY};
    tbl[8]  = '{1'b1, 32'hFFFFFFFF,   32'd5,        32'hFFFFFFFF, 32'd0,          EARLY};
    tbl[9]  = '{1'b0, 32'hDEADBEEF,   32'h00001234, 32'd1899,     32'd801701,     33};
    tbl[10] = '{1'b1, 32'h80000000,   32'd3,        32'hFFFFFFFE, -32'd715827882, 33};

    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    tick();
    tick();
    chk("rst hi", bus.hi_o, 32'd0);
    chk("rst lo", bus.lo_o, 32'd0);
    chk("rst ready", 32'(bus.ready_o), 32'd0);
    chk("rst whilo", 32'(bus.whilo_o), 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

    // Annul in the middle of iteration: no write, results keep previous values.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    for (int n = 1; n <= 10; n++) tick();
    bus.annul_i = 1'b1;
    #1;
    chk("annul stall", 32'(bus.stallreq_o), 32'd0);
    tick();
    chk("annul ready", 32'(bus.ready_o), 32'd0);
    chk("annul whilo", 32'(bus.whilo_o), 32'd0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    rcnt = 0;
    wcnt = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bus.ready_o) rcnt++;
      if (bus.whilo_o) wcnt++;
    end
    chk("annul no_ready", 32'(rcnt), 32'd0);
    chk("annul no_whilo", 32'(wcnt), 32'd0);
    chk("annul hi_kept", bus.hi_o, tbl[10].hi);
    chk("annul lo_kept", bus.lo_o, tbl[10].lo);

    // Annul in the first END cycle suppresses the write strobe.
    bus.opdata1_i = 32'd5;
    bus.opdata2_i = 32'd0;
    bus.start_i = 1'b1;
    lat = 0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      tick();
      if (bus.ready_o) lat = n;
    end
    chk("endannul latency", 32'(lat), 32'd2);
    bus.annul_i = 1'b1;
    #1;
    chk("endannul whilo", 32'(bus.whilo_o), 32'd0);
    tick();
    chk("endannul ready", 32'(bus.ready_o), 32'd0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    tick();

    // Reset mid-iteration clears outputs and aborts.
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    for (int n = 1; n <= 5; n++) tick();
    rst = 1'b0;
    tick();
    chk("midrst hi", bus.hi_o, 32'd0);
    chk("midrst lo", bus.lo_o, 32'd0);
    chk("midrst ready", 32'(bus.ready_o), 32'd0);
    chk("midrst whilo", 32'(bus.whilo_o), 32'd0);
    rst = 1'b1;
    bus.start_i = 1'b0;
    rcnt = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bus.ready_o || bus.whilo_o) rcnt++;
    end
    chk("midrst quiet", 32'(rcnt), 32'd0);
    run_vec(tbl[0], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
